toggle_activity_monitor: RTL and testbench

//  Downstream activity probe for seq_detector: samples a bus of monitored nets (bit0 = detector z,
//  bit1 = detector x, upper bits = other nets), counts per-bit toggles over a programmable cycle

---
 rtl/toggle_activity_monitor.sv | 141 ++++++++++++++
 tb/tb_toggle_activity_monitor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/toggle_activity_monitor.sv
// Switching-activity probe: counts per-bit toggles of sig_in over a programmable
// window, then streams the per-bit counts out over a valid/ready handshake.
module toggle_activity_monitor #(
    parameter int NSIG  = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSIG-1:0]  sig_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_idx,
    output logic [CNT_W-1:0] rd_count,
    output logic             done
);

    localparam int IDX_W = (NSIG > 1) ? $clog2(NSIG) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRIME   = 3'd1,
        S_MEASURE = 3'd2,
        S_DUMP    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [NSIG-1:0]  prev_r;
    logic [CNT_W-1:0] cnt_r [NSIG];
    logic [WIN_W-1:0] rem_r;
    logic [7:0]       idx_r;
    logic             last_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end else begin
            return c + CNT_W'(1);
        end
    endfunction

    assign last_s = (idx_r == 8'(NSIG - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_PRIME;
                else       state_s = S_IDLE;
            end
            S_PRIME:   state_s = S_MEASURE;
            S_MEASURE: begin
                if (rem_r == WIN_W'(1)) state_s = S_DUMP;
                else                    state_s = S_MEASURE;
            end
            S_DUMP: begin
                if (rd_ready && last_s) state_s = S_DONE;
                else                    state_s = S_DUMP;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Window datapath: previous sample, remaining compares, counters, readout index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= '0;
            rem_r  <= '0;
            idx_r  <= 8'd0;
            for (int i = 0; i < NSIG; i++) cnt_r[i] <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        // A zero window still performs one comparison
                        rem_r <= (win_len == '0) ? WIN_W'(1) : win_len;
                        idx_r <= 8'd0;
                        for (int i = 0; i < NSIG; i++) cnt_r[i] <= '0;
                    end
                end
                S_PRIME: begin
                    prev_r <= sig_in;
                end
                S_MEASURE: begin
                    prev_r <= sig_in;
                    rem_r  <= rem_r - WIN_W'(1);
                    idx_r  <= 8'd0;
                    for (int i = 0; i < NSIG; i++) begin
                        if (sig_in[i] != prev_r[i]) cnt_r[i] <= sat_inc(cnt_r[i]);
                    end
                end
                S_DUMP: begin
                    if (rd_ready) idx_r <= last_s ? 8'd0 : idx_r + 8'd1;
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    // Outputs decoded from the state register only
    always_comb begin
        busy     = 1'b0;
        rd_valid = 1'b0;
        done     = 1'b0;
        rd_count = '0;
        rd_idx   = idx_r;
        case (state_r)
            S_IDLE: busy = 1'b0;
            S_PRIME, S_MEASURE: busy = 1'b1;
            S_DUMP: begin
                busy     = 1'b1;
                rd_valid = 1'b1;
                rd_count = cnt_r[idx_r[IDX_W-1:0]];
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench: random and directed windows on two monitors (16-bit and 4-bit counters),
// readout checked against a sample-history toggle-count model.
module tb_toggle_activity_monitor;

    localparam int NSIG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sig_in = 4'd0;
    logic        start = 1'b0;
    logic [15:0] win_len = 16'd0;
    logic        rd_ready = 1'b0;
    logic        busy, rd_valid, done, busy2, rd_valid2, done2;
    logic [7:0]  rd_idx, rd_idx2;
    logic [15:0] rd_count;
    logic [3:0]  rd_count2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] smp [$];

    toggle_activity_monitor #(.NSIG(4), .CNT_W(16), .WIN_W(16)) u_dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .win_len(win_len),
        .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx),
        .rd_count(rd_count), .done(done));

    toggle_activity_monitor #(.NSIG(4), .CNT_W(4), .WIN_W(16)) u_sat (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .win_len(win_len),
        .busy(busy2), .rd_valid(rd_valid2), .rd_ready(rd_ready), .rd_idx(rd_idx2),
        .rd_count(rd_count2), .done(done2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Toggles seen on bit b across the recorded samples, clipped at the counter ceiling
    function automatic int model_cnt(input int b, input int cw);
        int t = 0;
        int top = (1 << cw) - 1;
        for (int k = 1; k < smp.size(); k++)
            if (smp[k][b] != smp[k-1][b]) t++;
        return (t > top) ? top : t;
    endfunction

    // mode 0 random, 1 bit0 toggling, 2 fixed table; bp stalls readout 3 cycles; poke pulses start
    task automatic run(input int w, input int mode, input bit bp, input bit poke);
        int weff = (w == 0) ? 1 : w;
        int ex = 0;
        int cyc = 0;
        logic [3:0] tbl [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0011, 4'b0010};
        smp.delete();
        for (int k = 0; k <= weff; k++) begin
            case (mode)
                1:       smp.push_back(4'(k & 1));
                2:       smp.push_back(tbl[k]);
                default: smp.push_back(4'($urandom));
            endcase
        end
        win_len = 16'(w);
        start = 1'b1;
        tick();
        start = 1'b0;
        win_len = 16'($urandom_range(1, 40));
        chk("busy_start", busy, 1);
        chk("busy_start_sat", busy2, 1);
        for (int k = 0; k <= weff; k++) begin
            sig_in = smp[k];
            start = (poke && k == 1) ? 1'b1 : 1'b0;
            tick();
            if (k < weff) begin
                chk("busy_meas", busy, 1);
                chk("valid_meas", rd_valid, 0);
            end
        end
        start = 1'b0;
        sig_in = 4'($urandom);
        while (ex < NSIG && cyc < 200) begin
            rd_ready = bp ? (cyc >= 3) : ($urandom_range(0, 2) != 0);
            chk("rd_valid", rd_valid, 1);
            chk("rd_idx", rd_idx, ex);
            chk("rd_count", rd_count, model_cnt(ex, 16));
            chk("rd_idx_sat", rd_idx2, ex);
            chk("rd_count_sat", rd_count2, model_cnt(ex, 4));
            chk("done_dump", done, 0);
            tick();
            cyc++;
            if (rd_ready) ex++;
        end
        chk("dump_complete", ex, NSIG);
        rd_ready = 1'b0;
        start = poke;
        chk("done_pulse", done, 1);
        chk("done_pulse_sat", done2, 1);
        chk("valid_after_last", rd_valid, 0);
        chk("busy_on_done", busy, 1);
        tick();
        start = 1'b0;
        chk("done_clear", done, 0);
        chk("busy_after_done", busy, 0);
        tick();
        chk("start_on_done_ignored", busy, 0);
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_count", rd_count, 0);
        chk("rst_idx", rd_idx, 0);
        tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of a W=8 window after three compares
        win_len = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sig_in = 4'(k);
            tick();
        end
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_count", rd_count, 0);
        rst = 1'b0;
        tick();
        run(2, 0, 1'b0, 1'b0);

        run(8, 1, 1'b0, 1'b0);    // bit0 every cycle: (0,8),(1,0),(2,0),(3,0)
        run(4, 2, 1'b0, 1'b0);    // table: 2,1,0,0
        run(20, 1, 1'b0, 1'b0);   // 20 on wide counter, 15 on 4-bit counter
        run(6, 0, 1'b1, 1'b0);    // readout stalled three cycles
        run(0, 1, 1'b0, 1'b1);    // zero window, start poked mid-window and on done
        for (int r = 0; r < 8; r++)
            run($urandom_range(0, 24), 0, 1'b0, r[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
